// File: rtl/branch_predictor.sv
// Direct-mapped branch history table plus branch target buffer.
// The IF stage gets a zero-latency prediction from the registered table.
// The ID stage reports resolved branches; the block trains the table,
// raises a flush request on mispredict and keeps saturating statistics.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            mispredict_o,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     mis_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // Saturating 2-bit-style direction counter step.
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c,
                                                input logic t);
    if (t) return (c == CTR_MAX) ? c : c + CTR_W'(1);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  // Statistics counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic             valid_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [31:0]      br_cnt_q;
  logic [31:0]      mis_cnt_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_upd_pc;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_upd_pc = ^{upd_pc_i[XLEN-1:IDX_W+TAG_W+2], upd_pc_i[1:0]};

  // IF-stage lookup: reads registered state only, so a same-cycle update
  // is not forwarded and becomes visible on the following cycle.
  assign pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o && ctr_q[lk_idx][CTR_W-1];
  assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_i + XLEN'(4);

  // ID-stage resolution: flush on wrong direction or wrong taken target.
  assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && upd_pred_taken_i &&
                          (upd_target_i != upd_pred_target_i)));

  // Entry control state: valid bits and direction counters, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd_taken_i);
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

  // Entry payload: any taken resolution rewrites tag and target (on a hit
  // the tag is unchanged, on a miss this is the allocation).
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_valid_i && upd_taken_i) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target_i;
    end
  end

  // Resolved-branch and mispredict statistics, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (upd_valid_i) begin
      br_cnt_q <= cnt_sat_inc(br_cnt_q);
      if (mispredict_o) mis_cnt_q <= cnt_sat_inc(mis_cnt_q);
    end
  end

  assign br_cnt_o  = br_cnt_q;
  assign mis_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with an expectation queue.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        hit, taken;
  logic [31:0] target;
  logic        uv, ut, upt;
  logic [31:0] upc, utgt, uptgt;
  logic        mp;
  logic [31:0] brc, misc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  string       step;
  logic        exp_mp;
  logic [31:0] model_br, model_mis;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .CTR_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc),
    .pred_hit_o(hit), .pred_taken_o(taken), .pred_target_o(target),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_taken_i(ut), .upd_target_i(utgt),
    .upd_pred_taken_i(upt), .upd_pred_target_i(uptgt),
    .mispredict_o(mp), .br_cnt_o(brc), .mis_cnt_o(misc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic void push(input string t, input int s, input logic [31:0] e);
    exp_t x;
    x.tag = t; x.sig = s; x.exp = e;
    sbq.push_back(x);
  endfunction

  function automatic logic [31:0] observe(input int s);
    case (s)
      0: return {31'd0, hit};
      1: return {31'd0, taken};
      2: return target;
      3: return {31'd0, mp};
      4: return brc;
      default: return misc;
    endcase
  endfunction

  task automatic check_all();
    exp_t x;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      obs = observe(x.sig);
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s.%s observed=0x%0h expected=0x%0h", step, x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic look(input logic [31:0] p, input logic h, input logic tk,
                      input logic [31:0] tg);
    pc = p;
    push("hit", 0, {31'd0, h});
    push("taken", 1, {31'd0, tk});
    push("target", 2, tg);
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg, input logic emp);
    uv = 1'b1; upc = p; ut = t; utgt = tg; upt = pt; uptgt = ptg; exp_mp = emp;
  endtask

  task automatic noupd();
    uv = 1'b0; upc = '0; ut = 1'b0; utgt = '0; upt = 1'b0; uptgt = '0; exp_mp = 1'b0;
  endtask

  // Check everything queued for this cycle mid-cycle, then advance the model
  // through the rising edge.
  task automatic cycle(input string s);
    step = s;
    push("mispredict", 3, {31'd0, exp_mp});
    push("br_cnt", 4, model_br);
    push("mis_cnt", 5, model_mis);
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst) begin
      model_br = 0; model_mis = 0;
    end else if (uv) begin
      model_br++;
      if (exp_mp) model_mis++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = '0; noupd();
    model_br = 0; model_mis = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    look(32'h40, 0, 0, 32'h44);                                    cycle("reset_state");
    upd(32'h100, 1, 32'h80, 0, 32'h0, 1);                           cycle("alloc");
    noupd(); look(32'h100, 1, 1, 32'h80);                           cycle("alloc_hit");
    // same-cycle lookup returns the pre-update prediction
    upd(32'h100, 0, 32'h0, 1, 32'h80, 1); look(32'h100, 1, 1, 32'h80); cycle("hazard_old");
    noupd(); look(32'h100, 1, 0, 32'h104);                          cycle("ctr1");
    upd(32'h100, 0, 32'h0, 0, 32'h0, 0);                            cycle("nt_to0");
    upd(32'h100, 0, 32'h0, 0, 32'h0, 0);                            cycle("nt_sat0");
    noupd(); look(32'h100, 1, 0, 32'h104);                          cycle("ctr0");
    upd(32'h100, 1, 32'h80, 0, 32'h0, 1);                           cycle("t_to1");
    noupd(); look(32'h100, 1, 0, 32'h104);                          cycle("ctr1_after_sat");
    upd(32'h100, 1, 32'h80, 0, 32'h0, 1);                           cycle("t_to2");
    noupd(); look(32'h100, 1, 1, 32'h80);                           cycle("ctr2");
    upd(32'h100, 1, 32'h80, 1, 32'h80, 0);                          cycle("t_to3");
    upd(32'h100, 1, 32'h80, 1, 32'h80, 0);                          cycle("t_sat3");
    upd(32'h100, 0, 32'h0, 1, 32'h80, 1);                           cycle("nt_from3");
    noupd(); look(32'h100, 1, 1, 32'h80);                           cycle("ctr2_after_sat");
    look(32'h500, 0, 0, 32'h504);                                   cycle("alias_miss");
    upd(32'h500, 1, 32'h200, 0, 32'h0, 1);                          cycle("alias_alloc");
    noupd(); look(32'h500, 1, 1, 32'h200);                          cycle("alias_hit");
    look(32'h100, 0, 0, 32'h104);                                   cycle("evicted");
    upd(32'h500, 1, 32'h90, 1, 32'h80, 1);                          cycle("tgt_mismatch");
    noupd(); look(32'h500, 1, 1, 32'h90);                           cycle("tgt_new");
    upd(32'h500, 0, 32'h0, 1, 32'h90, 1);                           cycle("nt_from3b");
    noupd(); look(32'h500, 1, 1, 32'h90);                           cycle("ctr_inc_seen");
    upd(32'h144, 0, 32'h0, 0, 32'h0, 0);                            cycle("miss_nt");
    noupd(); look(32'h144, 0, 0, 32'h148);                          cycle("miss_nt_noalloc");
    // reset with a simultaneous update: table still visible this cycle
    rst = 1'b1; upd(32'h100, 1, 32'h80, 0, 32'h0, 1); look(32'h500, 1, 1, 32'h90);
    cycle("reset_with_upd");
    rst = 1'b0; noupd(); look(32'h500, 0, 0, 32'h504);              cycle("post_reset_a");
    look(32'h100, 0, 0, 32'h104);                                   cycle("post_reset_b");
    look(32'hFFFF_FFFC, 0, 0, 32'h0);                               cycle("pc_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
